// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// waits on data-memory ready with timeout, HALT status and retire counter.
module multicycle_control #(
   parameter int OPWIDTH   = 3,
   parameter int MCODEBITS = 4,
   parameter int TIMEOUT   = 15,
   parameter int CNTW      = 16
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic [MCODEBITS-1:0] instr,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCSrc,
   output logic                 Branch,
   output logic                 MemtoReg,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 ALUSrc,
   output logic                 RegWrite,
   output logic [OPWIDTH-1:0]   ALUOp,
   output logic                 Done,
   output logic                 Err,
   output logic [CNTW-1:0]      InstrCount,
   output logic [2:0]           State
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t          r_state;
   logic [3:0]      r_op;
   logic [TW-1:0]   r_wait;
   logic            r_err;
   logic [CNTW-1:0] r_cnt;

   logic [3:0] w_op;
   logic       w_load;
   logic       w_store;
   logic       w_mem;
   logic       w_biz;
   logic       w_retire;

   assign w_op    = instr[MCODEBITS-1 -: 4];
   assign w_load  = (r_op == 4'b0110);
   assign w_store = (r_op == 4'b0111);
   assign w_mem   = (r_op[3:1] == 3'b011);
   assign w_biz   = (r_op[3:1] == 3'b101);

   assign w_retire = ((r_state == S_EXEC) && w_biz)
                   || ((r_state == S_MEM) && mem_ready && w_store)
                   || (r_state == S_WB);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_op    <= 4'd0;
         r_wait  <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_retire && (r_cnt != {CNTW{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
         case (r_state)
            S_IDLE: if (Start) r_state <= S_FETCH;
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               r_op    <= w_op;
               r_state <= (w_op == 4'b0101) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               r_wait <= '0;
               if (w_mem)      r_state <= S_MEM;
               else if (w_biz) r_state <= S_FETCH;
               else            r_state <= S_WB;
            end
            S_MEM: begin
               // ready wins over a timeout reached in the same cycle
               if (mem_ready) begin
                  r_state <= w_store ? S_FETCH : S_WB;
               end else if (r_wait == TW'(TIMEOUT)) begin
                  r_err   <= 1'b1;
                  r_state <= S_HALT;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_WB: r_state <= S_FETCH;
            S_HALT: begin
               if (Start) begin
                  r_err   <= 1'b0;
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      Branch   = 1'b0;
      MemtoReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      ALUOp    = '0;
      case (r_state)
         S_FETCH: IRWrite = 1'b1;
         S_EXEC: begin
            unique case (1'b1)
               w_biz: begin
                  Branch  = 1'b1;
                  PCWrite = 1'b1;
                  PCSrc   = Zero;
                  ALUOp   = OPWIDTH'(3'b111);
               end
               w_mem: ALUOp = OPWIDTH'(3'b111);
               (r_op[3:1] == 3'b110): ALUSrc = 1'b1;
               (r_op[3:1] == 3'b111): begin
                  ALUOp  = OPWIDTH'(3'b110);
                  ALUSrc = 1'b1;
               end
               (r_op[3:1] == 3'b100): ALUOp = OPWIDTH'(3'b101);
               default: ALUOp = OPWIDTH'(r_op[2:0]);
            endcase
         end
         S_MEM: begin
            MemRead  = w_load;
            MemWrite = w_store;
            PCWrite  = w_store && mem_ready;
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = w_load;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
   end

   assign Done       = (r_state == S_HALT) && !r_err;
   assign Err        = (r_state == S_HALT) && r_err;
   assign InstrCount = r_cnt;
   assign State      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control against an
// instruction-level reference model; a CNTW=2 copy checks saturation.
module tb_multicycle_control;

   localparam int TO = 15;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Start = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [3:0] instr = 4'd0;

   logic        IRWrite, PCWrite, PCSrc, Branch, MemtoReg;
   logic        MemRead, MemWrite, ALUSrc, RegWrite, Done, Err;
   logic [2:0]  ALUOp, State;
   logic [15:0] InstrCount;

   logic        s_ir, s_pw, s_ps, s_br, s_mt, s_mr, s_mw, s_as, s_rw, s_dn, s_er;
   logic [2:0]  s_op, s_st;
   logic [1:0]  s_cnt;

   multicycle_control #(.OPWIDTH(3), .MCODEBITS(4), .TIMEOUT(TO), .CNTW(16)) u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .instr(instr),
      .Zero(Zero), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch),
      .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
      .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .Done(Done),
      .Err(Err), .InstrCount(InstrCount), .State(State)
   );

   multicycle_control #(.OPWIDTH(3), .MCODEBITS(4), .TIMEOUT(TO), .CNTW(2)) u_sat (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .instr(instr),
      .Zero(Zero), .mem_ready(mem_ready),
      .IRWrite(s_ir), .PCWrite(s_pw), .PCSrc(s_ps), .Branch(s_br),
      .MemtoReg(s_mt), .MemRead(s_mr), .MemWrite(s_mw),
      .ALUSrc(s_as), .RegWrite(s_rw), .ALUOp(s_op), .Done(s_dn),
      .Err(s_er), .InstrCount(s_cnt), .State(s_st)
   );

   always #5 Clk = ~Clk;

   int total  = 0;
   int passed = 0;
   int m_cnt  = 0;
   bit halted = 0;
   bit m_err  = 0;

   function automatic logic [16:0] v(
      input logic ir, pw, ps, br, mt, mr, mw, as, rw,
      input logic [2:0] op, input logic dn, er, input logic [2:0] st);
      return {ir, pw, ps, br, mt, mr, mw, as, rw, op, dn, er, st};
   endfunction

   function automatic logic [16:0] obs();
      return {IRWrite, PCWrite, PCSrc, Branch, MemtoReg, MemRead, MemWrite,
              ALUSrc, RegWrite, ALUOp, Done, Err, State};
   endfunction

   function automatic logic rb();
      return logic'($urandom % 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, o, e);
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_cnt"}, 32'(InstrCount), 32'(m_cnt));
      chk({tag, "_sat"}, 32'(s_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
   endtask

   task automatic cyc(input logic st, z, rdy, input logic [16:0] e, input string tag);
      @(negedge Clk);
      Start = st;
      Zero = z;
      mem_ready = rdy;
      #1;
      chk(tag, 32'(obs()), 32'(e));
      chk_cnt(tag);
   endtask

   task automatic start_idle();
      cyc(1'b1, rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,0,0,3'd0), "idle_start");
   endtask

   task automatic restart(input int waitc);
      for (int i = 0; i < waitc; i++)
         cyc(1'b0, rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,!m_err,m_err,3'd6), "halt_hold");
      cyc(1'b1, rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,!m_err,m_err,3'd6), "halt_start");
      halted = 0;
      m_err  = 0;
   endtask

   // Instruction-level model: expected strobes for each cycle of one instruction.
   task automatic run_instr(input logic [3:0] op, input int dly, input logic z);
      logic [2:0] ao;
      logic       as;
      int         cls;
      logic       ld;
      logic       stv;
      ao = 3'd0; as = 1'b0; cls = 0;
      instr = op;
      cyc(rb(), rb(), rb(), v(1,0,0,0,0,0,0,0,0,3'd0,0,0,3'd1), "fetch");
      cyc(rb(), rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,0,0,3'd2), "decode");
      if (op == 4'b0101) begin
         cyc(1'b0, rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,1,0,3'd6), "halt");
         halted = 1;
         m_err  = 0;
         return;
      end
      case (op)
         4'd0: ao = 3'd0;
         4'd1: ao = 3'd1;
         4'd2: ao = 3'd2;
         4'd3: ao = 3'd3;
         4'd4: ao = 3'd4;
         4'd8, 4'd9: ao = 3'd5;
         4'd12, 4'd13: begin ao = 3'd0; as = 1'b1; end
         4'd14, 4'd15: begin ao = 3'd6; as = 1'b1; end
         4'd6, 4'd7: begin ao = 3'd7; cls = 1; end
         default: begin ao = 3'd7; cls = 2; end
      endcase
      if (cls == 2) begin
         cyc(rb(), z, rb(), v(0,1,z,1,0,0,0,0,0,3'd7,0,0,3'd3), "exec_biz");
         m_cnt++;
         return;
      end
      cyc(rb(), rb(), rb(), v(0,0,0,0,0,0,0,as,0,ao,0,0,3'd3), "exec");
      if (cls == 0) begin
         cyc(rb(), rb(), rb(), v(0,1,0,0,0,0,0,0,1,3'd0,0,0,3'd5), "wb");
         m_cnt++;
         return;
      end
      ld  = (op == 4'b0110);
      stv = (op == 4'b0111);
      for (int k = 0; k <= TO; k++) begin
         logic rdy;
         rdy = (k == dly);
         cyc(rb(), rb(), rdy, v(0,stv&rdy,0,0,0,ld,stv,0,0,3'd0,0,0,3'd4), "mem");
         if (rdy) begin
            if (!stv)
               cyc(rb(), rb(), rb(), v(0,1,0,0,1,0,0,0,1,3'd0,0,0,3'd5), "wb_ld");
            m_cnt++;
            return;
         end
      end
      cyc(1'b0, rb(), rb(), v(0,0,0,0,0,0,0,0,0,3'd0,0,1,3'd6), "timeout");
      halted = 1;
      m_err  = 1;
   endtask

   initial begin
      @(negedge Clk);
      @(negedge Clk);
      #1;
      chk("reset", 32'(obs()), 32'd0);
      chk_cnt("reset");
      Reset_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,3'd0,0,0,3'd0), "idle");

      start_idle();
      run_instr(4'b0001, 0, 1'b0);
      run_instr(4'b1010, 0, 1'b1);
      run_instr(4'b1010, 0, 1'b0);
      run_instr(4'b0110, 3, 1'b0);
      run_instr(4'b0111, 0, 1'b0);
      run_instr(4'b0111, 99, 1'b0);
      restart(2);
      run_instr(4'b0111, TO, 1'b0);
      run_instr(4'b0101, 0, 1'b0);
      restart(1);
      run_instr(4'b1100, 0, 1'b0);

      instr = 4'b0111;
      cyc(1'b0, 1'b0, 1'b0, v(1,0,0,0,0,0,0,0,0,3'd0,0,0,3'd1), "r_fetch");
      cyc(1'b0, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,3'd0,0,0,3'd2), "r_decode");
      cyc(1'b0, 1'b0, 1'b0, v(0,0,0,0,0,0,0,0,0,3'd7,0,0,3'd3), "r_exec");
      cyc(1'b0, 1'b0, 1'b0, v(0,0,0,0,0,0,1,0,0,3'd0,0,0,3'd4), "r_mem");
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      m_cnt = 0;
      chk("rst_mid", 32'(obs()), 32'd0);
      chk_cnt("rst_mid");
      @(negedge Clk);
      Reset_n = 1'b1;
      start_idle();
      run_instr(4'b0011, 0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         int r;
         int d;
         r = int'($urandom % 10);
         d = (r == 0) ? 99 : (r == 1) ? TO : int'($urandom_range(0, 3));
         run_instr(4'($urandom % 16), d, rb());
         if (halted) restart(int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
